// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, writeback request type and register one-hot helper
package wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count
// Ports: clk/reset (async, active-high); push/din write, pop/dout read (dout is the head, show-ahead);
// full/empty flags; count = occupancy. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write port arbiter merging core and accelerator writebacks
// Ports: clk/reset (async, active-high); core_we/core_rd/core_data core writeback (top priority);
// acc_issue/acc_issue_rd mark a pending destination; acc_valid/acc_ready/acc_rd/acc_data accelerator results;
// write_reg/rd/data_in registered reg_file write; pending scoreboard; drain_req FIFO full; fifo_count occupancy.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_we,
  input  logic [REG_ADDR_W-1:0]   core_rd,
  input  logic [XLEN-1:0]         core_data,
  input  logic                    acc_issue,
  input  logic [REG_ADDR_W-1:0]   acc_issue_rd,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic [REG_ADDR_W-1:0]   acc_rd,
  input  logic [XLEN-1:0]         acc_data,
  output logic                    write_reg,
  output logic [REG_ADDR_W-1:0]   rd,
  output logic [XLEN-1:0]         data_in,
  output logic [NUM_REGS-1:0]     pending,
  output logic                    drain_req,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic core_win, push, pop, full, empty;
  logic [REG_ADDR_W+XLEN-1:0] head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0] head_data;
  logic [CW-1:0] count_nxt;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  sync_fifo #(.W(REG_ADDR_W + XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din({acc_rd, acc_data}),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign head_rd = head[REG_ADDR_W+XLEN-1:XLEN];
  assign head_data = head[XLEN-1:0];
  assign acc_ready = ~reset & ~full;
  assign core_win = core_we & (core_rd != '0);
  assign pop = ~core_win & ~empty;
  // x0 results complete the handshake but are never stored
  assign push = acc_valid & acc_ready & (acc_rd != '0);
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);
  assign set_mask = (acc_issue && acc_issue_rd != '0) ? reg_bit(acc_issue_rd) : '0;
  assign clr_mask = pop ? reg_bit(head_rd) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      write_reg <= 1'b0;
      rd <= '0;
      data_in <= '0;
      pending <= '0;
      drain_req <= 1'b0;
    end else begin
      write_reg <= core_win | pop;
      if (core_win | pop) rd <= core_win ? core_rd : head_rd;
      if (core_win | pop) data_in <= core_win ? core_data : head_data;
      // set after clear: a newly issued op to the same register stays outstanding
      pending <= (pending & ~clr_mask) | set_mask;
      drain_req <= count_nxt == CW'(DEPTH);
    end
endmodule
